branch_cmp_pipe: RTL

- Parametrised, pipelined successor to the combinational rv32i branch comparator.
- Resolves RV32I branch conditions (beq/bne/blt/bge/bltu/bgeu) for the pipelined datapath, with valid/ready flow control, flush, tag passthrough and mispredict detection against a supplied prediction.
- Sits between the ID/EX operand latch and the PC-redirect logic. Illegal funct3 encodings are flagged, not silently dropped.

---
 rtl/branch_cmp_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/branch_cmp_pipe.sv
// Pipelined RV32I branch comparator: valid/ready flow control, flush, tag passthrough, mispredict flag.
// Define BRCMP_PERF_CNT_EN to add saturating taken/mispredict/illegal result counters.
module branch_cmp_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_cmpop,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_br_en,
   output logic             out_illegal,
   output logic             out_mispredict,
   output logic [TAG_W-1:0] out_tag
`ifdef BRCMP_PERF_CNT_EN
   ,
   output logic [31:0]      cnt_taken,
   output logic [31:0]      cnt_mispredict,
   output logic [31:0]      cnt_illegal
`endif
);

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_ILL2 = 3'b010,
      F3_ILL3 = 3'b011,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } branch_funct3_t;

   branch_funct3_t op;
   logic           cmp_br;
   logic           cmp_ill;
   logic           cmp_mis;
   logic           accept;

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] adv;
   logic              br_q  [STAGES];
   logic              ill_q [STAGES];
   logic              mis_q [STAGES];
   logic [TAG_W-1:0]  tag_q [STAGES];

   assign op = branch_funct3_t'(in_cmpop);

   always_comb begin
      cmp_br  = 1'b0;
      cmp_ill = 1'b0;
      unique case (op)
         F3_BEQ:  cmp_br = (in_a == in_b);
         F3_BNE:  cmp_br = (in_a != in_b);
         F3_BLT:  cmp_br = ($signed(in_a) <  $signed(in_b));
         F3_BGE:  cmp_br = ($signed(in_a) >= $signed(in_b));
         F3_BLTU: cmp_br = (in_a <  in_b);
         F3_BGEU: cmp_br = (in_a >= in_b);
         default: cmp_ill = 1'b1;
      endcase
   end

   assign cmp_mis = cmp_br ^ in_pred_taken;

   // Stage k advances iff some stage at or beyond k is empty, or the consumer is
   // ready; this is the unrolled form of the per-stage advance chain.
   always_comb begin
      logic full_tail;
      adv       = '0;
      full_tail = 1'b1;
      for (int unsigned k = 0; k < STAGES; k++) begin
         full_tail = 1'b1;
         for (int unsigned j = k; j < STAGES; j++) begin
            full_tail = full_tail & valid_q[j];
         end
         adv[k] = out_ready | ~full_tail;
      end
   end

   assign in_ready = adv[0] & ~flush;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            br_q[k]  <= 1'b0;
            ill_q[k] <= 1'b0;
            mis_q[k] <= 1'b0;
            tag_q[k] <= '0;
         end
      end else begin
         if (flush) begin
            valid_q <= '0;
         end else begin
            if (adv[0]) valid_q[0] <= accept;
            for (int unsigned k = 1; k < STAGES; k++) begin
               if (adv[k]) valid_q[k] <= valid_q[k-1];
            end
         end

         // Payload only moves with a real entry, so post-reset zeros persist until first use.
         if (accept) begin
            br_q[0]  <= cmp_br;
            ill_q[0] <= cmp_ill;
            mis_q[0] <= cmp_mis;
            tag_q[0] <= in_tag;
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k] && valid_q[k-1] && !flush) begin
               br_q[k]  <= br_q[k-1];
               ill_q[k] <= ill_q[k-1];
               mis_q[k] <= mis_q[k-1];
               tag_q[k] <= tag_q[k-1];
            end
         end
      end
   end

   assign out_valid      = valid_q[STAGES-1];
   assign out_br_en      = br_q[STAGES-1];
   assign out_illegal    = ill_q[STAGES-1];
   assign out_mispredict = mis_q[STAGES-1];
   assign out_tag        = tag_q[STAGES-1];

`ifdef BRCMP_PERF_CNT_EN
   logic out_hs;

   // A handshake in the flush cycle still counts: the consumer took that result.
   assign out_hs = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_taken      <= '0;
         cnt_mispredict <= '0;
         cnt_illegal    <= '0;
      end else if (out_hs) begin
         if (out_br_en && (cnt_taken != '1))           cnt_taken      <= cnt_taken + 32'd1;
         if (out_mispredict && (cnt_mispredict != '1)) cnt_mispredict <= cnt_mispredict + 32'd1;
         if (out_illegal && (cnt_illegal != '1))       cnt_illegal    <= cnt_illegal + 32'd1;
      end
   end
`endif

endmodule
